// File: rtl/conv_pkg.sv
// Shared definitions for the conv front end: default image geometry, pixel width,
// line-buffer bank count and the write-scheduler state encoding.
package conv_pkg;

  localparam int DEF_BIT_DEPTH    = 8;
  localparam int DEF_IMAGE_WIDTH  = 1920;
  localparam int DEF_IMAGE_HEIGHT = 1080;
  localparam int DEF_ADDR_W       = 11;
  localparam int PIX_W            = 3 * DEF_BIT_DEPTH;
  localparam int NUM_BANKS        = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [1:0] ptr);
    bank_onehot      = '0;
    bank_onehot[ptr] = 1'b1;
  endfunction

endpackage

// File: rtl/lbs_occ_tracker.sv
// Line-buffer occupancy counter (0..NUM_BANKS) with simultaneous inc/dec,
// sticky overrun/underrun flags and per-cycle event strobes.
module lbs_occ_tracker
  import conv_pkg::*;
(
  input  logic       clk,
  input  logic       RESET,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  input  logic       row_start,
  output logic [2:0] occ,
  output logic       ovf,
  output logic       unf,
  output logic       ovf_evt,
  output logic       unf_evt
);

  localparam logic [2:0] OCC_FULL = 3'(NUM_BANKS);

  logic dec_ok;
  logic inc_ok;

  assign ovf_evt = row_start && (occ == OCC_FULL);
  assign unf_evt = dec && (occ == 3'd0);
  assign dec_ok  = dec && (occ != 3'd0);
  assign inc_ok  = inc && ((occ != OCC_FULL) || dec_ok);

  always_ff @(posedge clk) begin
    if (RESET || clr) begin
      occ <= 3'd0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (inc_ok && !dec_ok) begin
        occ <= occ + 3'd1;
      end else if (dec_ok && !inc_ok) begin
        occ <= occ - 3'd1;
      end
      if (ovf_evt) ovf <= 1'b1;
      if (unf_evt) unf <= 1'b1;
    end
  end

endmodule

// File: rtl/line_buf_scheduler.sv
// Write-side scheduler for the 4-bank rotating line buffer of the 3x3 conv datapath.
// Optional error-event counter enabled by defining LBS_ERR_CNT_EN.
module line_buf_scheduler
  import conv_pkg::*;
#(
  parameter int BIT_DEPTH    = DEF_BIT_DEPTH,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int ADDR_W       = DEF_ADDR_W
)(
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   vs_in,
  input  logic                   de_in,
  input  logic [3*BIT_DEPTH-1:0] pix_in,
  output logic [NUM_BANKS-1:0]   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [3*BIT_DEPTH-1:0] wr_data,
  output logic                   start_rd,
  input  logic                   fin_rd,
  output logic [2:0]             occ,
  output logic                   busy,
  output logic                   ovf,
  output logic                   unf,
  output logic [15:0]            err_cnt
);

  localparam int                ROW_W    = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [ADDR_W-1:0] COL_MAX  = ADDR_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [ROW_W-1:0]  ROW_ALL  = ROW_W'(IMAGE_HEIGHT);

  state_t              state;
  logic [1:0]          bank_ptr;
  logic [ADDR_W-1:0]   col;
  logic                col_full;
  logic                de_d;
  logic                row_ok;
  logic [ROW_W-1:0]    rows_in;
  logic [ROW_W-1:0]    released;

  logic active;
  logic row_rise;
  logic row_start;
  logic row_end;
  logic row_accept;
  logic wr_now;
  logic fin_req;
  logic fin_ok;
  logic ovf_evt;
  logic unf_evt;

  // vs_in dominates: any row or release event coinciding with it is discarded.
  assign active     = (state == FILL) || (state == RUN);
  assign row_rise   = de_in && !de_d;
  assign row_start  = row_rise && active && !vs_in;
  assign row_end    = de_d && !de_in && row_ok && !vs_in;
  assign row_accept = row_start && !ovf_evt && (rows_in != ROW_ALL);
  assign wr_now     = de_in && !col_full && !vs_in && (row_rise ? row_accept : row_ok);
  assign fin_req    = fin_rd && !vs_in;
  assign fin_ok     = fin_req && !unf_evt;
  assign busy       = (state != IDLE);

  lbs_occ_tracker u_occ (
    .clk       (clk),
    .RESET     (RESET),
    .clr       (vs_in),
    .inc       (row_end),
    .dec       (fin_req),
    .row_start (row_start),
    .occ       (occ),
    .ovf       (ovf),
    .unf       (unf),
    .ovf_evt   (ovf_evt),
    .unf_evt   (unf_evt)
  );

  // Stage p0 -> p1: register write strobe, address and pixel; advance FSM and counters.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= IDLE;
      bank_ptr <= 2'd0;
      col      <= '0;
      col_full <= 1'b0;
      de_d     <= 1'b0;
      row_ok   <= 1'b0;
      rows_in  <= '0;
      released <= '0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      start_rd <= 1'b0;
    end else begin
      de_d     <= de_in;
      wr_data  <= pix_in;
      start_rd <= (state == RUN);
      wr_en    <= wr_now ? bank_onehot(bank_ptr) : '0;
      if (wr_now) wr_addr <= col;

      if (vs_in) begin
        state    <= FILL;
        bank_ptr <= 2'd0;
        col      <= '0;
        col_full <= 1'b0;
        row_ok   <= 1'b0;
        rows_in  <= '0;
        released <= '0;
      end else begin
        if (row_rise) row_ok <= row_accept;

        // Address sticks at the last column; surplus pixels are discarded.
        if (wr_now) begin
          if (col == COL_MAX) col_full <= 1'b1;
          else                col      <= col + ADDR_W'(1);
        end

        if (de_d && !de_in) begin
          col      <= '0;
          col_full <= 1'b0;
          row_ok   <= 1'b0;
        end

        if (row_end) begin
          bank_ptr <= bank_ptr + 2'd1;
          rows_in  <= rows_in + ROW_W'(1);
        end

        if (fin_ok) released <= released + ROW_W'(1);

        case (state)
          FILL:    if (occ >= 3'd3) state <= RUN;
          RUN:     if (fin_ok && (released == ROW_LAST)) state <= DRAIN;
          DRAIN:   state <= IDLE;
          default: ;
        endcase
      end
    end
  end

`ifdef LBS_ERR_CNT_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  logic       mid_vs;
  logic [1:0] n_evt;

  assign mid_vs = vs_in && (state != IDLE);
  assign n_evt  = 2'(ovf_evt) + 2'(unf_evt) + 2'(mid_vs);

  always_ff @(posedge clk) begin
    if (RESET) begin
      err_cnt <= '0;
    end else if (n_evt != 2'd0) begin
      err_cnt <= sat_add16(err_cnt, n_evt);
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_line_buf_scheduler.sv
// Directed bench for line_buf_scheduler: a full-size instance plus an IMAGE_HEIGHT=4,
// IMAGE_WIDTH=8 instance sharing the same stimulus.
module tb_line_buf_scheduler;

`ifdef LBS_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        vs_in = 1'b0;
  logic        de_in = 1'b0;
  logic        fin_rd = 1'b0;
  logic [23:0] pix_in = '0;

  logic [3:0]  wr_en,    h_wr_en;
  logic [10:0] wr_addr,  h_wr_addr;
  logic [23:0] wr_data,  h_wr_data;
  logic        start_rd, h_start_rd;
  logic [2:0]  occ,      h_occ;
  logic        busy,     h_busy;
  logic        ovf,      h_ovf;
  logic        unf,      h_unf;
  logic [15:0] err_cnt,  h_err_cnt;

  int checks   = 0;
  int failures = 0;
  bit sel_h4   = 1'b0;

  logic [3:0]  f_en;
  int          n_wr;
  logic [10:0] l_addr;
  logic [23:0] l_data;

  always #5 clk = ~clk;

  line_buf_scheduler dut (
    .clk(clk), .RESET(RESET), .vs_in(vs_in), .de_in(de_in), .pix_in(pix_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .start_rd(start_rd),
    .fin_rd(fin_rd), .occ(occ), .busy(busy), .ovf(ovf), .unf(unf), .err_cnt(err_cnt)
  );

  line_buf_scheduler #(.IMAGE_HEIGHT(4), .IMAGE_WIDTH(8)) dut_h4 (
    .clk(clk), .RESET(RESET), .vs_in(vs_in), .de_in(de_in), .pix_in(pix_in),
    .wr_en(h_wr_en), .wr_addr(h_wr_addr), .wr_data(h_wr_data), .start_rd(h_start_rd),
    .fin_rd(fin_rd), .occ(h_occ), .busy(h_busy), .ovf(h_ovf), .unf(h_unf), .err_cnt(h_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk); RESET = 1'b1;
    @(negedge clk); RESET = 1'b0;
  endtask

  task automatic vs_pulse();
    @(negedge clk); vs_in = 1'b1;
    @(negedge clk); vs_in = 1'b0;
  endtask

  task automatic fin_pulse();
    @(negedge clk); fin_rd = 1'b1;
    @(negedge clk); fin_rd = 1'b0;
  endtask

  // Drives one row of n pixels (value 0x0A0000+i); optional fin_rd on the row-end cycle.
  task automatic drive_row(input int n, input bit fin_last, output logic [3:0] first_en,
                           output int nw, output logic [10:0] last_addr, output logic [23:0] last_data);
    logic [3:0] en;
    first_en = '0; nw = 0; last_addr = '0; last_data = '0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        en = sel_h4 ? h_wr_en : wr_en;
        if (i == 1) first_en = en;
        if (en != 4'd0) begin
          nw++;
          last_addr = sel_h4 ? h_wr_addr : wr_addr;
          last_data = sel_h4 ? h_wr_data : wr_data;
        end
      end
      if (i < n) begin
        de_in  = 1'b1;
        pix_in = 24'h0A0000 + 24'(i);
      end else begin
        de_in  = 1'b0;
        fin_rd = fin_last;
      end
    end
    @(negedge clk); fin_rd = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_start_rd", start_rd, 0);
    check("rst_occ", occ, 0);
    check("rst_busy", busy, 0);
    check("rst_ovf_unf", {ovf, unf}, 0);
    check("rst_err_cnt", err_cnt, 0);
    RESET = 1'b0;

    // 1: three rows fill banks 0,1,2; start_rd one cycle after RUN
    vs_pulse();
    check("t1_busy", busy, 1);
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    check("t1_r1_en", f_en, 4'b0001);
    check("t1_r1_nwr", n_wr, 1920);
    check("t1_r1_addr", l_addr, 11'd1919);
    check("t1_r1_data", l_data, 24'h0A077F);
    check("t1_r1_occ", occ, 1);
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    check("t1_r2_en", f_en, 4'b0010);
    check("t1_r2_occ", occ, 2);
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    check("t1_r3_en", f_en, 4'b0100);
    check("t1_r3_occ", occ, 3);
    check("t1_start_fill", start_rd, 0);
    @(negedge clk);
    check("t1_start_enter", start_rd, 0);
    @(negedge clk);
    check("t1_start_run", start_rd, 1);

    // 2: fin_rd coincident with row end keeps occ, pointer still advances
    drive_row(1920, 1, f_en, n_wr, l_addr, l_data);
    check("t2_en", f_en, 4'b1000);
    check("t2_occ", occ, 3);
    check("t2_unf", unf, 0);
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    check("t2_wrap_en", f_en, 4'b0001);
    check("t2_wrap_occ", occ, 4);

    // 3: fifth row with all banks full is dropped
    reset_pulse();
    vs_pulse();
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    check("t3_r4_en", f_en, 4'b1000);
    check("t3_r4_occ", occ, 4);
    check("t3_ovf_before", ovf, 0);
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    check("t3_r5_nwr", n_wr, 0);
    check("t3_ovf", ovf, 1);
    check("t3_occ", occ, 4);
    check("t3_err", err_cnt, ERR_EN ? 1 : 0);

    // 4: underrun in FILL; vs_in clears the sticky flags
    vs_pulse();
    check("t4_vs_ovf", ovf, 0);
    check("t4_vs_occ", occ, 0);
    check("t4_vs_busy", busy, 1);
    check("t4_vs_err", err_cnt, ERR_EN ? 2 : 0);
    fin_pulse();
    check("t4_unf_occ", occ, 0);
    check("t4_unf", unf, 1);
    check("t4_unf_err", err_cnt, ERR_EN ? 3 : 0);
    vs_pulse();
    check("t4_unf_clr", unf, 0);
    check("t4_err2", err_cnt, ERR_EN ? 4 : 0);

    // 5: IMAGE_HEIGHT=4 frame runs to completion; width saturation on the first row
    sel_h4 = 1'b1;
    reset_pulse();
    check("t5_rst_err", h_err_cnt, 0);
    vs_pulse();
    drive_row(10, 0, f_en, n_wr, l_addr, l_data);
    check("t5_r1_en", f_en, 4'b0001);
    check("t5_sat_nwr", n_wr, 8);
    check("t5_sat_addr", l_addr, 11'd7);
    check("t5_sat_data", l_data, 24'h0A0007);
    drive_row(8, 0, f_en, n_wr, l_addr, l_data);
    drive_row(8, 0, f_en, n_wr, l_addr, l_data);
    check("t5_r3_occ", h_occ, 3);
    drive_row(8, 1, f_en, n_wr, l_addr, l_data);
    check("t5_r4_en", f_en, 4'b1000);
    check("t5_r4_occ", h_occ, 3);
    check("t5_run_start", h_start_rd, 1);
    fin_pulse();
    fin_pulse();
    check("t5_occ1", h_occ, 1);
    fin_pulse();
    check("t5_drain_busy", h_busy, 1);
    check("t5_drain_occ", h_occ, 0);
    @(negedge clk);
    check("t5_idle_busy", h_busy, 0);
    check("t5_idle_start", h_start_rd, 0);
    check("t5_flags", {h_ovf, h_unf}, 0);
    drive_row(8, 0, f_en, n_wr, l_addr, l_data);
    check("t5_r5_nwr", n_wr, 0);
    check("t5_r5_occ", h_occ, 0);
    sel_h4 = 1'b0;

    // 6: reset in the middle of row 2
    reset_pulse();
    vs_pulse();
    drive_row(1920, 0, f_en, n_wr, l_addr, l_data);
    check("t6_r1_occ", occ, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      de_in  = 1'b1;
      pix_in = 24'h0B0000 + 24'(i);
    end
    @(negedge clk);
    check("t6_pre_en", wr_en, 4'b0010);
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    check("t6_wr_en", wr_en, 0);
    check("t6_wr_addr", wr_addr, 0);
    check("t6_wr_data", wr_data, 0);
    check("t6_occ", occ, 0);
    check("t6_busy_start", {busy, start_rd}, 0);
    check("t6_flags", {ovf, unf}, 0);
    check("t6_err", err_cnt, 0);
    @(negedge clk);
    check("t6_de_held_en", wr_en, 0);
    de_in = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
